mem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single data memory between the multicycle MIPS instruction-fetch unit (master 0) and the load/store unit (master 1). It accepts one word access per cycle from a req/gnt handshake, drives the memory's write and read address/data/enable inputs from registered state, and returns read data with a per-master valid pulse. Sits between the core's fetch/execute control and the data memory.

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (fetch unit, load/store unit),
// the arbiter and the shared data memory.
interface mem_arbiter_if #(
  parameter int DW = 32
);
  // master 0: instruction fetch
  logic          m0_req;
  logic          m0_we;
  logic [11:2]   m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;
  // master 1: load/store
  logic          m1_req;
  logic          m1_we;
  logic [11:2]   m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;
  // memory side
  logic [11:2]   mem_waddr;
  logic [11:2]   mem_raddr;
  logic [DW-1:0] mem_din;
  logic          mem_wren;
  logic [DW-1:0] mem_dout;

  // arbiter view
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_dout,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_waddr, mem_raddr, mem_din, mem_wren
  );

  // requester / memory environment view
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_dout,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_waddr, mem_raddr, mem_din, mem_wren
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the shared data memory.
// A granted master is masked for one edge, so its held req is not re-granted
// immediately; the other master can take the next cycle (back-to-back).
module mem_arbiter #(
  parameter int RESET_PRIO = 0,
  parameter int DW         = 32
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic PRIO_INIT = (RESET_PRIO != 0) ? 1'b1 : 1'b0;

  state_t        state_r;
  state_t        state_s;
  logic          own_r;
  logic          prio_r;
  logic          gnt0_r;
  logic          gnt1_r;
  logic          rvalid0_r;
  logic          rvalid1_r;
  logic [DW-1:0] rdata0_r;
  logic [DW-1:0] rdata1_r;
  logic [11:2]   addr_r;
  logic [DW-1:0] din_r;
  logic          wren_r;

  logic          elig0_s;
  logic          elig1_s;
  logic          grant_s;
  logic          winner_s;
  logic          win_we_s;
  logic [11:2]   win_addr_s;
  logic [DW-1:0] win_wdata_s;
  logic          rd_done_s;

  // Arbitration: pick the winner among eligible requests and the next state.
  always_comb begin
    elig0_s     = bus.m0_req & ~gnt0_r;
    elig1_s     = bus.m1_req & ~gnt1_r;
    grant_s     = 1'b0;
    winner_s    = 1'b0;
    state_s     = IDLE;
    if (elig0_s && elig1_s) begin
      grant_s  = 1'b1;
      winner_s = prio_r;
    end else if (elig0_s) begin
      grant_s  = 1'b1;
      winner_s = 1'b0;
    end else if (elig1_s) begin
      grant_s  = 1'b1;
      winner_s = 1'b1;
    end else begin
      grant_s  = 1'b0;
      winner_s = 1'b0;
    end
    if (winner_s) begin
      win_we_s    = bus.m1_we;
      win_addr_s  = bus.m1_addr;
      win_wdata_s = bus.m1_wdata;
    end else begin
      win_we_s    = bus.m0_we;
      win_addr_s  = bus.m0_addr;
      win_wdata_s = bus.m0_wdata;
    end
    case (state_r)
      IDLE:    state_s = grant_s ? BUSY : IDLE;
      BUSY:    state_s = grant_s ? BUSY : IDLE;
      default: state_s = IDLE;
    endcase
    // a read finishes at the edge that ends a BUSY cycle
    rd_done_s = (state_r == BUSY) && !wren_r;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant pulses, owner/priority update and latched memory-side request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_r  <= 1'b0;
      prio_r <= PRIO_INIT;
      gnt0_r <= 1'b0;
      gnt1_r <= 1'b0;
      addr_r <= 10'd0;
      din_r  <= {DW{1'b0}};
      wren_r <= 1'b0;
    end else begin
      gnt0_r <= grant_s & ~winner_s;
      gnt1_r <= grant_s & winner_s;
      wren_r <= grant_s & win_we_s;
      if (grant_s) begin
        own_r  <= winner_s;
        prio_r <= ~winner_s;
        addr_r <= win_addr_s;
        din_r  <= win_wdata_s;
      end
    end
  end

  // Read return: capture memory data for the owner and pulse its rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= {DW{1'b0}};
      rdata1_r  <= {DW{1'b0}};
    end else begin
      rvalid0_r <= rd_done_s & ~own_r;
      rvalid1_r <= rd_done_s & own_r;
      if (rd_done_s) begin
        if (own_r) begin
          rdata1_r <= bus.mem_dout;
        end else begin
          rdata0_r <= bus.mem_dout;
        end
      end
    end
  end

  assign bus.m0_gnt    = gnt0_r;
  assign bus.m1_gnt    = gnt1_r;
  assign bus.m0_rvalid = rvalid0_r;
  assign bus.m1_rvalid = rvalid1_r;
  assign bus.m0_rdata  = rdata0_r;
  assign bus.m1_rdata  = rdata1_r;
  assign bus.mem_waddr = addr_r;
  assign bus.mem_raddr = addr_r;
  assign bus.mem_din   = din_r;
  assign bus.mem_wren  = wren_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1024-word memory.
module tb_mem_arbiter;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DW(DW)) bus();

  mem_arbiter #(.RESET_PRIO(0), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [0:1023];
  logic          pre_en = 1'b0;
  logic [9:0]    pre_addr = 10'd0;
  logic [DW-1:0] pre_data = 32'd0;

  // memory: synchronous write, combinational read; preload port for setup
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.mem_wren) mem[bus.mem_waddr] <= bus.mem_din;
  end
  assign bus.mem_dout = mem[bus.mem_raddr];

  int vectors = 0;
  int errors  = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 10'd0; bus.m0_wdata = 32'd0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 10'd0; bus.m1_wdata = 32'd0;
  endtask

  task automatic preload(input logic [9:0] a, input logic [DW-1:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    tick;
    pre_en = 1'b0;
  endtask

  task automatic apply_reset;
    idle_inputs;
    rst_n = 1'b0;
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    idle_inputs;
    rst_n = 1'b0;
    repeat (2) tick;
    vectors++; if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.mem_wren} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.mem_wren}); end
    vectors++; if (bus.m0_rdata !== 32'd0) begin errors++; $display("FAIL reset_m0_rdata: got %h expected 0", bus.m0_rdata); end
    vectors++; if (bus.m1_rdata !== 32'd0) begin errors++; $display("FAIL reset_m1_rdata: got %h expected 0", bus.m1_rdata); end
    vectors++; if (bus.mem_waddr !== 10'd0 || bus.mem_raddr !== 10'd0) begin
      errors++; $display("FAIL reset_addr: got %h/%h expected 0/0", bus.mem_waddr, bus.mem_raddr); end
    vectors++; if (bus.mem_din !== 32'd0) begin errors++; $display("FAIL reset_din: got %h expected 0", bus.mem_din); end
    rst_n = 1'b1;
    tick;
    preload(10'h005, 32'h11111111);
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 10'h005; bus.m0_wdata = 32'hDEADBEEF;
    tick;
    bus.m0_req = 1'b0;
    vectors++; if (bus.mem_wren !== 1'b1) begin errors++; $display("FAIL midbusy_wren_before: got %b expected 1", bus.mem_wren); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus.mem_wren !== 1'b0) begin errors++; $display("FAIL midbusy_wren_async: got %b expected 0", bus.mem_wren); end
    vectors++; if (bus.m0_gnt !== 1'b0) begin errors++; $display("FAIL midbusy_gnt: got %b expected 0", bus.m0_gnt); end
    vectors++; if (bus.mem_waddr !== 10'd0 || bus.mem_din !== 32'd0) begin
      errors++; $display("FAIL midbusy_bus: got addr %h din %h expected 0/0", bus.mem_waddr, bus.mem_din); end
    tick;
    vectors++; if (mem[5] !== 32'h11111111) begin errors++; $display("FAIL midbusy_mem5: got %h expected 11111111", mem[5]); end
    vectors++; if (bus.m0_rvalid !== 1'b0) begin errors++; $display("FAIL midbusy_rvalid: got %b expected 0", bus.m0_rvalid); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_write_read;
    idle_inputs;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 10'h010; bus.m1_wdata = 32'h12345678;
    tick;
    vectors++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b expected 01", {bus.m0_gnt, bus.m1_gnt}); end
    vectors++; if (bus.mem_wren !== 1'b1 || bus.mem_waddr !== 10'h010 || bus.mem_din !== 32'h12345678) begin
      errors++; $display("FAIL wr_bus: got wren %b addr %h din %h expected 1/010/12345678", bus.mem_wren, bus.mem_waddr, bus.mem_din); end
    bus.m1_we = 1'b0;
    tick;
    vectors++; if (bus.m1_gnt !== 1'b0 || bus.mem_wren !== 1'b0) begin
      errors++; $display("FAIL wr_masked: got gnt %b wren %b expected 0/0", bus.m1_gnt, bus.mem_wren); end
    vectors++; if (mem[16] !== 32'h12345678) begin errors++; $display("FAIL wr_commit: got %h expected 12345678", mem[16]); end
    tick;
    bus.m1_req = 1'b0;
    vectors++; if (bus.m1_gnt !== 1'b1 || bus.mem_wren !== 1'b0) begin
      errors++; $display("FAIL rd_gnt: got gnt %b wren %b expected 1/0", bus.m1_gnt, bus.mem_wren); end
    tick;
    vectors++; if (bus.m1_rvalid !== 1'b1 || bus.m0_rvalid !== 1'b0) begin
      errors++; $display("FAIL rd_rvalid: got m1 %b m0 %b expected 1/0", bus.m1_rvalid, bus.m0_rvalid); end
    vectors++; if (bus.m1_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_data: got %h expected 12345678", bus.m1_rdata); end
    tick;
    vectors++; if (bus.m1_rvalid !== 1'b0 || bus.m1_rdata !== 32'h12345678) begin
      errors++; $display("FAIL rd_hold: got rvalid %b rdata %h expected 0/12345678", bus.m1_rvalid, bus.m1_rdata); end
  endtask

  task automatic test_contention;
    apply_reset;
    preload(10'h001, 32'hC0DE0001);
    preload(10'h002, 32'hC0DE0002);
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 10'h001;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 10'h002;
    tick;
    bus.m0_req = 1'b0;
    vectors++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10 || bus.mem_raddr !== 10'h001) begin
      errors++; $display("FAIL cont_first: got gnt %b addr %h expected 10/001", {bus.m0_gnt, bus.m1_gnt}, bus.mem_raddr); end
    tick;
    bus.m1_req = 1'b0;
    vectors++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01 || bus.mem_raddr !== 10'h002) begin
      errors++; $display("FAIL cont_second: got gnt %b addr %h expected 01/002", {bus.m0_gnt, bus.m1_gnt}, bus.mem_raddr); end
    vectors++; if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 32'hC0DE0001) begin
      errors++; $display("FAIL cont_m0_rd: got rvalid %b rdata %h expected 1/c0de0001", bus.m0_rvalid, bus.m0_rdata); end
    tick;
    vectors++; if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b01 || bus.m1_rdata !== 32'hC0DE0002) begin
      errors++; $display("FAIL cont_m1_rd: got rvalid %b rdata %h expected 01/c0de0002", {bus.m0_rvalid, bus.m1_rvalid}, bus.m1_rdata); end
    tick;
  endtask

  task automatic test_fairness;
    int   grants;
    logic exp0;
    grants = 0;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 10'h001;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 10'h002;
    for (int i = 0; i < 20; i++) begin
      tick;
      exp0 = ((i % 2) == 0);
      grants += int'(bus.m0_gnt) + int'(bus.m1_gnt);
      vectors++; if ({bus.m0_gnt, bus.m1_gnt} !== {exp0, ~exp0}) begin
        errors++; $display("FAIL fair_gnt[%0d]: got %b expected %b", i, {bus.m0_gnt, bus.m1_gnt}, {exp0, ~exp0}); end
      if (i > 0) begin
        vectors++; if ({bus.m0_rvalid, bus.m1_rvalid} !== {~exp0, exp0}) begin
          errors++; $display("FAIL fair_rvalid[%0d]: got %b expected %b", i, {bus.m0_rvalid, bus.m1_rvalid}, {~exp0, exp0}); end
      end
    end
    idle_inputs;
    vectors++; if (grants != 20) begin errors++; $display("FAIL fair_total: got %0d expected 20", grants); end
    repeat (2) tick;
  endtask

  task automatic test_back_to_back;
    preload(10'h3FF, 32'h0BADF00D);
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 10'h3FF; bus.m1_wdata = 32'hA5A5A5A5;
    tick;
    vectors++; if (bus.m1_gnt !== 1'b1 || bus.mem_wren !== 1'b1 || bus.mem_waddr !== 10'h3FF) begin
      errors++; $display("FAIL raw_wr: got gnt %b wren %b addr %h expected 1/1/3ff", bus.m1_gnt, bus.mem_wren, bus.mem_waddr); end
    bus.m1_req = 1'b0;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 10'h3FF;
    tick;
    bus.m0_req = 1'b0;
    vectors++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10 || bus.mem_wren !== 1'b0 || bus.mem_raddr !== 10'h3FF) begin
      errors++; $display("FAIL raw_rd_gnt: got gnt %b wren %b addr %h expected 10/0/3ff", {bus.m0_gnt, bus.m1_gnt}, bus.mem_wren, bus.mem_raddr); end
    tick;
    vectors++; if (bus.m0_rvalid !== 1'b1 || bus.m1_rvalid !== 1'b0 || bus.m0_rdata !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL raw_data: got rvalid %b/%b rdata %h expected 1/0/a5a5a5a5", bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata); end
    tick;
  endtask

  task automatic test_streaming;
    int   pulses;
    logic exp0;
    pulses = 0;
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 10'h020; bus.m0_wdata = 32'h5EED0000;
    for (int i = 0; i < 10; i++) begin
      tick;
      exp0 = ((i % 2) == 0);
      pulses += int'(bus.m0_gnt);
      vectors++; if ({bus.m0_gnt, bus.m1_gnt, bus.mem_wren} !== {exp0, 1'b0, exp0}) begin
        errors++; $display("FAIL stream[%0d]: got gnt/gnt/wren %b expected %b", i, {bus.m0_gnt, bus.m1_gnt, bus.mem_wren}, {exp0, 1'b0, exp0}); end
    end
    idle_inputs;
    vectors++; if (pulses != 5) begin errors++; $display("FAIL stream_pulses: got %0d expected 5", pulses); end
    tick;
    vectors++; if (mem[32] !== 32'h5EED0000) begin errors++; $display("FAIL stream_mem: got %h expected 5eed0000", mem[32]); end
  endtask

  initial begin
    idle_inputs;
    rst_n = 1'b0;
    test_reset;
    test_write_read;
    test_contention;
    test_fairness;
    test_back_to_back;
    test_streaming;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
